// File: rtl/mips_alu_seq.sv
// Registered multi-cycle MIPS ALU: single-cycle logic/arith ops, iterative shift-add MUL and restoring DIV.
// Optional feature macro ALU_SEQ_HI_EN adds the `hi` port (high product / remainder).
module mips_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
`ifdef ALU_SEQ_HI_EN
    ,
    output logic [WIDTH-1:0] hi
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1001;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;
    logic                 busy_q, busy_d;
    logic [WIDTH-1:0]     alu_s;
    logic                 slt_s;
    logic                 iter_op_s;
    logic [2*WIDTH-1:0]   step_s;
`ifdef ALU_SEQ_HI_EN
    logic [WIDTH-1:0]     hi_q, hi_d;
    assign hi = hi_q;
`endif

    // acc holds {partial product high, multiplier}; add multiplicand on LSB then shift right.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0]   mcand);
        logic [WIDTH:0] sum;
        if (acc[0]) begin
            sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end else begin
            sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        end
        return {sum, acc[WIDTH-1:1]};
    endfunction

    // acc holds {remainder, dividend/quotient}; shift one dividend bit in, subtract if it fits.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0]   divisor);
        logic [WIDTH:0] trial;
        logic [WIDTH:0] diff;
        trial = acc[2*WIDTH-1:WIDTH-1];
        diff  = trial - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            return {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            return {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    endfunction

    assign slt_s     = $signed(a) < $signed(b);
    assign iter_op_s = (sel == OP_MUL) || ((sel == OP_DIV) && (b != {WIDTH{1'b0}}));
    assign step_s    = is_div_q ? div_step(acc_q, opnd_q) : mul_step(acc_q, opnd_q);

    // Single-cycle result; DIV only reaches here with a zero divisor.
    always_comb begin
        alu_s = {WIDTH{1'b0}};
        case (sel)
            OP_ADD:  alu_s = a + b;
            OP_SUB:  alu_s = a - b;
            OP_DIV:  alu_s = {WIDTH{1'b1}};
            OP_AND:  alu_s = a & b;
            OP_OR:   alu_s = a | b;
            OP_NOR:  alu_s = ~(a | b);
            OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, slt_s};
            OP_XOR:  alu_s = a ^ b;
            default: alu_s = {WIDTH{1'b0}};
        endcase
    end

    // Next-state and output-register logic for the accept/iterate handshake.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        busy_d   = 1'b0;
`ifdef ALU_SEQ_HI_EN
        hi_d     = hi_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && iter_op_s) begin
                    state_d  = S_RUN;
                    cnt_d    = CNT_LAST;
                    is_div_d = (sel == OP_DIV);
                    opnd_d   = (sel == OP_DIV) ? b : a;
                    acc_d    = {{WIDTH{1'b0}}, ((sel == OP_DIV) ? a : b)};
                    busy_d   = 1'b1;
                end else if (start) begin
                    result_d = alu_s;
                    zero_d   = (alu_s == {WIDTH{1'b0}});
                    done_d   = 1'b1;
                    dbz_d    = (sel == OP_DIV);
`ifdef ALU_SEQ_HI_EN
                    hi_d     = (sel == OP_DIV) ? a : {WIDTH{1'b0}};
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = step_s;
                if (cnt_q == CNT_ZERO) begin
                    state_d  = S_IDLE;
                    result_d = step_s[WIDTH-1:0];
                    zero_d   = (step_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    done_d   = 1'b1;
                    dbz_d    = 1'b0;
`ifdef ALU_SEQ_HI_EN
                    hi_d     = step_s[2*WIDTH-1:WIDTH];
`endif
                end else begin
                    cnt_d  = cnt_q - CNT_ONE;
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; rst aborts any iteration without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= CNT_ZERO;
            is_div_q <= 1'b0;
            opnd_q   <= {WIDTH{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            result_q <= {WIDTH{1'b0}};
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef ALU_SEQ_HI_EN
            hi_q     <= {WIDTH{1'b0}};
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            busy_q   <= busy_d;
`ifdef ALU_SEQ_HI_EN
            hi_q     <= hi_d;
`endif
        end
    end

    assign result      = result_q;
    assign zero        = zero_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_alu_seq.sv
// Self-checking bench for mips_alu_seq: directed steps plus random ops against an arithmetic reference.
module tb_mips_alu_seq;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_NOR = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8;
    localparam logic [3:0] OP_XOR = 4'd9;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic        done;
    logic        div_by_zero;
`ifdef ALU_SEQ_HI_EN
    logic [31:0] hi;
`endif

    int tests = 0;
    int fails = 0;

    mips_alu_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sel         (sel),
        .a           (a),
        .b           (b),
        .result      (result),
        .zero        (zero),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
`ifdef ALU_SEQ_HI_EN
        ,
        .hi          (hi)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_model(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] er, output logic [31:0] eh,
                                      output logic edz, output int lat);
        logic [63:0] p;
        er = 32'd0; eh = 32'd0; edz = 1'b0; lat = 1;
        case (s)
            OP_ADD: er = x + y;
            OP_SUB: er = x - y;
            OP_MUL: begin
                p = {32'd0, x} * {32'd0, y};
                er = p[31:0]; eh = p[63:32]; lat = 32;
            end
            OP_DIV: begin
                if (y == 32'd0) begin
                    er = 32'hFFFF_FFFF; eh = x; edz = 1'b1;
                end else begin
                    er = x / y; eh = x % y; lat = 32;
                end
            end
            OP_AND: er = x & y;
            OP_OR:  er = x | y;
            OP_NOR: er = ~(x | y);
            OP_SLT: er = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            OP_XOR: er = x ^ y;
            default: er = 32'd0;
        endcase
    endfunction

    task automatic chk_outputs(input string tag, input logic [31:0] er, input logic [31:0] eh,
                               input logic edz);
        chk({tag, " result"}, result, er);
        chk({tag, " zero"}, zero, (er == 32'd0));
        chk({tag, " dbz"}, div_by_zero, edz);
`ifdef ALU_SEQ_HI_EN
        chk({tag, " hi"}, hi, eh);
`else
        if (eh === 32'hDEAD_0000) tests = tests;
`endif
    endtask

    // Called at a negedge; issues one op and checks it through completion.
    task automatic run_op(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y,
                          input bit poke, input string tag);
        logic [31:0] er, eh;
        logic        edz;
        int          lat, n;
        bit          busy_gap;
        ref_model(s, x, y, er, eh, edz, lat);
        start = 1'b1; sel = s; a = x; b = y;
        @(negedge clk);
        start = 1'b0; sel = 4'($urandom); a = $urandom; b = $urandom;
        if (lat == 1) begin
            chk({tag, " done"}, done, 1'b1);
            chk({tag, " busy"}, busy, 1'b0);
            chk_outputs(tag, er, eh, edz);
            @(negedge clk);
            chk({tag, " done_drop"}, done, 1'b0);
            chk({tag, " busy_after"}, busy, 1'b0);
        end else begin
            chk({tag, " busy_start"}, busy, 1'b1);
            chk({tag, " done_start"}, done, 1'b0);
            n = 0;
            busy_gap = 1'b0;
            while (done !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
                if (poke && n == 10) begin
                    start = 1'b1; sel = OP_ADD; a = 32'd1; b = 32'd1;
                end else begin
                    start = 1'b0;
                end
                if (done !== 1'b1 && busy !== 1'b1) busy_gap = 1'b1;
            end
            chk({tag, " latency"}, n, 32);
            chk({tag, " busy_gap"}, busy_gap, 1'b0);
            chk({tag, " busy_end"}, busy, 1'b0);
            chk_outputs(tag, er, eh, edz);
        end
    endtask

    initial begin
        logic [3:0]  bs [4];
        logic [31:0] bx [4];
        logic [31:0] by [4];
        logic [31:0] er, eh;
        logic        edz;
        int          lat;
        int          done_seen;
        logic [3:0]  rs;
        logic [31:0] rx, ry;

        rst = 1'b1; start = 1'b0; sel = OP_NOP; a = 32'd0; b = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset result", result, 32'd0);
        chk("reset zero", zero, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset dbz", div_by_zero, 1'b0);
`ifdef ALU_SEQ_HI_EN
        chk("reset hi", hi, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        run_op(OP_ADD, 32'd5, 32'd7, 1'b0, "add5_7");
        run_op(OP_SUB, 32'd3, 32'd3, 1'b0, "sub3_3");
        run_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0, "slt_neg");
        run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b0, "mul_2p32");
        run_op(OP_DIV, 32'd100, 32'd7, 1'b1, "div100_7");
        run_op(OP_DIV, 32'd9, 32'd0, 1'b0, "div_zero");
        run_op(OP_AND, 32'h0000_00F0, 32'h0000_003C, 1'b0, "and_f0_3c");

        // Abort a multiply with rst at iteration 10.
        start = 1'b1; sel = OP_MUL; a = 32'h0000_1234; b = 32'h0000_5678;
        @(negedge clk);
        start = 1'b0;
        chk("abort busy_start", busy, 1'b1);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort result", result, 32'd0);
        chk("abort zero", zero, 1'b1);
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        chk("abort no_done", done_seen, 0);
        run_op(OP_ADD, 32'd1, 32'd1, 1'b0, "add1_1");

        // rst and start together: the request must be dropped.
        rst = 1'b1; start = 1'b1; sel = OP_ADD; a = 32'd5; b = 32'd5;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start result", result, 32'd0);
        chk("rst_start done", done, 1'b0);
        @(negedge clk);
        chk("rst_start done_later", done, 1'b0);
        chk("rst_start result_later", result, 32'd0);

        // Back-to-back single-cycle ops keep done high every cycle.
        bs = '{OP_ADD, OP_OR, OP_SUB, OP_SLT};
        bx = '{32'd10, 32'hA0A0_0000, 32'd4, 32'h8000_0000};
        by = '{32'd20, 32'h0000_0505, 32'd9, 32'h7FFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            start = 1'b1; sel = bs[i]; a = bx[i]; b = by[i];
            ref_model(bs[i], bx[i], by[i], er, eh, edz, lat);
            @(negedge clk);
            chk("b2b done", done, 1'b1);
            chk("b2b result", result, er);
        end
        start = 1'b0;
        @(negedge clk);
        chk("b2b done_drop", done, 1'b0);

        // MUL then DIV issued in the done cycle of the previous op.
        run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul_max");
        run_op(OP_DIV, 32'hFFFF_FFFF, 32'd1, 1'b0, "div_by1");
        run_op(OP_DIV, 32'd3, 32'd10, 1'b0, "div_small");

        for (int i = 0; i < 40; i++) begin
            rs = 4'($urandom_range(0, 15));
            rx = $urandom;
            ry = $urandom;
            if ($urandom_range(0, 4) == 0) ry = 32'd0;
            if ($urandom_range(0, 4) == 0) rx = ry;
            if ($urandom_range(0, 4) == 0) ry = 32'($urandom_range(1, 9));
            run_op(rs, rx, ry, 1'b0, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_alu_seq.md
# mips_alu_seq

Registered, multi-cycle ALU that consumes the 4-bit operation select produced by the ALU control stage and the two 32-bit operands from the register file or immediate mux. Single-cycle operations complete one clock after `start`. Multiply and divide run iteratively over WIDTH cycles. A start/busy/done handshake lets the datapath controller stall the pipeline while a result is outstanding.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- sel  input  4  operation select from ALU control.
- a  input  WIDTH  operand A; captured at accept.
- b  input  WIDTH  operand B; captured at accept.
- result  output  WIDTH  registered result; holds until the next completion.
- zero  output  1  registered (result==0), updated with result.
- busy  output  1  high while a mul/div is iterating.
- done  output  1  one-cycle completion pulse.
- div_by_zero  output  1  registered; set on completion of a DIV with b==0, cleared on any other completion.
- hi  output  WIDTH  present only with ALU_SEQ_HI_EN; see Configuration.

## Operation
- Select codes:
  - 0000 NOP → 0
  - 0001 ADD a+b
  - 0010 SUB a−b
  - 0011 MUL a×b (low WIDTH bits)
  - 0100 DIV unsigned a/b
  - 0101 AND
  - 0110 OR
  - 0111 NOR
  - 1000 SLT, signed (a<b) ? 1 : 0
  - 1001 XOR
  - 1010–1111 → 0
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT compares in two's complement.
- FSM states:
  - IDLE: accept start.
    - MUL/DIV with b≠0 → RUN.
    - Every other op, including DIV with b==0, completes directly from IDLE.
  - RUN: one iteration per cycle; a down-counter runs from WIDTH−1 to 0.
    - At counter 0: write result, pulse done, → IDLE.
- MUL: shift-add over a 2·WIDTH product register.
- DIV: restoring; quotient to result, remainder internal.
- DIV with b==0:
  - No iteration.
  - result = all ones, div_by_zero=1, done after one cycle.
- start while busy=1 is ignored; in-flight operands and operation are unaffected.
- sel, a, b are don't-care except in the accept cycle.

## Timing
- Reset values:
  - result=0, zero=1, busy=0, done=0, div_by_zero=0, hi=0.
  - State=IDLE, counter=0.
- Single-cycle ops (and DIV by zero), accepted at edge k:
  - result, zero and done=1 are visible after edge k.
  - done drops after edge k+1 unless a new op completes.
  - busy stays 0.
- MUL/DIV accepted at edge k:
  - busy=1 after edge k.
  - Iterations occur at edges k+1..k+WIDTH.
  - After edge k+WIDTH: result valid, done=1, busy=0.
  - Latency is WIDTH cycles from accept to done.
- Back-to-back:
  - A new start may be accepted in the same cycle done is high, since busy=0.
  - Single-cycle ops can issue every cycle, giving done=1 continuously.
- rst during RUN:
  - Aborts the operation.
  - All outputs return to reset values at that edge.
  - No done pulse is produced.
- rst and start in the same cycle: rst wins; the request is dropped.

## Configuration
- ALU_SEQ_HI_EN defined:
  - `hi` port exists.
  - After MUL, hi = high WIDTH bits of the product.
  - After DIV, hi = remainder; DIV by zero gives hi = a.
  - After all other ops, hi = 0.
  - hi updates only on completion.
- ALU_SEQ_HI_EN undefined:
  - No `hi` port.
  - High product and remainder are discarded; the remainder register is still required by the DIV iteration.
  - All other behaviour is identical.

## Test plan
- Reset, then ADD a=5, b=7 → result=12, zero=0, done high exactly one cycle later, busy never high.
- SUB a=3, b=3 → result=0, zero=1. Then SLT a=0xFFFFFFFF, b=1 → result=1.
- MUL a=0x00010000, b=0x00010000 → busy for 32 cycles, then result=0, zero=1, done pulse. With HI_EN, hi=1.
- DIV a=100, b=7 → result=14 after 32 cycles (hi=2 with HI_EN).
  - Pulse start with sel=ADD mid-divide → ignored; the divide result is unchanged.
- DIV a=9, b=0 → result=0xFFFFFFFF, div_by_zero=1, done after one cycle.
  - A following AND a=0xF0, b=0x3C → result=0x30, div_by_zero=0.
- Start MUL, assert rst at iteration 10 → result=0, zero=1, busy=0, no done pulse.
  - A fresh ADD 1+1 then returns 2 normally.
